// File: rtl/stall_ctrl.sv
// Pipeline interlock: detects D-stage data hazards against E/M producers and
// tracks the multi-cycle multiply/divide unit, stalling IF/ID and flushing ID/EX.
module stall_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_use_D,
    input  logic        start_md,
    input  logic [1:0]  md_op,
    output logic        Stall,
    output logic        Flush_E,
    output logic        busy,
    output logic [3:0]  md_cnt,
    output logic [31:0] stall_cnt,
    output logic        md_err
);

    typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

    localparam logic [3:0] MultCycles = 4'd5;
    localparam logic [3:0] DivCycles  = 4'd10;

    state_e      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        md_err_q, md_err_d;
    logic        hazard_rs, hazard_rt, hazard_md;

    // A source of $0 never matches, which also covers producers with A3 == 0.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] a3_e, input logic [1:0] t_e,
                                        input logic [4:0] a3_m, input logic [1:0] t_m);
        return (src != 5'd0) && (tuse != 2'd3) &&
               (((src == a3_e) && (tuse < t_e)) || ((src == a3_m) && (tuse < t_m)));
    endfunction

    always_comb begin
        busy      = (state_q != StIdle);
        hazard_rs = src_hazard(rs_D, tuse_rs_D, A3_E, tnew_E, A3_M, tnew_M);
        hazard_rt = src_hazard(rt_D, tuse_rt_D, A3_E, tnew_E, A3_M, tnew_M);
        hazard_md = md_use_D && (busy || start_md);
        // Gated by reset so the interlock is quiet while reset is held.
        Stall     = reset && (hazard_rs || hazard_rt || hazard_md);
        Flush_E   = Stall;
        md_cnt    = md_cnt_q;
        stall_cnt = stall_cnt_q;
        md_err    = md_err_q;
    end

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        md_err_d    = md_err_q || (start_md && busy);
        stall_cnt_d = (Stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_md) begin
                    state_d  = md_op[1] ? StDiv : StMult;
                    md_cnt_d = md_op[1] ? DivCycles : MultCycles;
                end
            end
            StMult, StDiv: begin
                if (md_cnt_q <= 4'd1) begin
                    state_d  = StIdle;
                    md_cnt_d = 4'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = StIdle;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 32'd0;
            md_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            md_err_q    <= md_err_d;
        end
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 rs_D, rt_D  in  5 each  source register numbers of the instruction held in the IF/ID register.
REQ-005 tuse_rs_D, tuse_rt_D  in  2 each  cycles until D needs rs/rt; 3 = operand not used.
REQ-006 A3_E, A3_M  in  5 each  destination register of the E/M-stage instruction; 0 = no write.
REQ-007 tnew_E, tnew_M  in  2 each  cycles until the E/M-stage result is available.
REQ-008 md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-009 start_md  in  1  E-stage instruction starts a multiply/divide this cycle.
REQ-010 md_op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start_md.
REQ-011 Stall  out  1  freezes PC and IF/ID register (IF/ID holds IR, PC+4, PC+8).
REQ-012 Flush_E  out  1  inserts a bubble into ID/EX.
REQ-013 busy  out  1  multiply/divide unit occupied.
REQ-014 md_cnt  out  4  remaining busy cycles.
REQ-015 stall_cnt  out  32  total stall cycles since reset.
REQ-016 md_err  out  1  sticky: start_md received while busy.

Function
REQ-017 FSM states SHALL be IDLE, MULT, DIV; busy = (state != IDLE).
REQ-018 IDLE + start_md: md_op[1]=0 -> MULT with md_cnt=5; md_op[1]=1 -> DIV with md_cnt=10; transition on the same edge as start_md.
REQ-019 In MULT/DIV, md_cnt SHALL decrement by 1 per cycle; on the edge where md_cnt=1 it becomes 0 and the state returns to IDLE.
REQ-020 Net latency: busy high for exactly 5 (mult/multu) or 10 (div/divu) cycles after the start edge.
REQ-021 start_md while busy SHALL be ignored (state and md_cnt unchanged) and SHALL set md_err until reset.
REQ-022 Data-hazard stall (rs): rs_D != 0 and tuse_rs_D != 3 and ((rs_D == A3_E and tuse_rs_D < tnew_E) or (rs_D == A3_M and tuse_rs_D < tnew_M)); same rule for rt.
REQ-023 Multiply/divide stall: md_use_D and (busy or start_md).
REQ-024 Stall SHALL be the OR of REQ-022 and REQ-023, combinational from current inputs and state (zero-cycle latency).
REQ-025 Flush_E SHALL equal Stall.
REQ-026 A3 == 0 SHALL never cause a stall, even if rs_D/rt_D == 0.
REQ-027 stall_cnt SHALL increment on each edge where Stall=1, saturating at 0xFFFFFFFF (no wrap).
REQ-028 When md_cnt reaches 0 and md_use_D=1 with no data hazard, Stall SHALL deassert in that same cycle.

Reset
REQ-029 While reset=0: state=IDLE, md_cnt=0, busy=0, stall_cnt=0, md_err=0, Stall=0, Flush_E=0.
REQ-030 Reset asserted mid-operation SHALL abort the multiply/divide with no residual busy after release.
REQ-031 The first rising edge after reset returns to 1 SHALL be processed normally.

Verification
REQ-032 Load-use: A3_E=5, tnew_E=2, rs_D=5, tuse_rs_D=1 -> Stall=Flush_E=1; next cycle with A3_M=5, tnew_M=1 -> Stall=0; stall_cnt=1.
REQ-033 Zero register: A3_E=0, tnew_E=2, rs_D=0, tuse_rs_D=0 -> Stall=0.
REQ-034 div then mfhi: start_md=1, md_op=10, md_use_D=1 held -> busy for 10 cycles, Stall=1 for 11 cycles (start cycle + 10), md_cnt 10..1, then Stall=0.
REQ-035 mult then start_md while busy -> md_cnt continues 5..1 unchanged, md_err=1 until reset.
REQ-036 Reset pulse low at md_cnt=4 of a div -> busy=0, md_cnt=0, stall_cnt=0 immediately; after release no stall with md_use_D=1.
REQ-037 Saturation: preload stall_cnt to 0xFFFFFFFE by forcing Stall=1 (or backdoor), 3 stall cycles -> stall_cnt holds 0xFFFFFFFF.
